filter_mode_scheduler: RTL and testbench



---
 rtl/filter_mode_scheduler.sv | 148 ++++++++++++++
 tb/tb_filter_mode_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_scheduler.sv
// Frame-synchronous arbiter sharing one frame-buffer write port among NUM_SRC filter streams.
// Optional macro SCHED_BLANK_SWITCH_EN: first frame after any source switch is written with zero data.
module filter_mode_scheduler #(
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int NUM_SRC     = 4,
  parameter int HOLD_FRAMES = 60,
  localparam int AW = $clog2(IMG_WIDTH*IMG_HEIGHT),
  localparam int SW = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SW-1:0]         mode_req,
  input  logic                  mode_req_valid,
  input  logic [NUM_SRC-1:0]    src_we,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC*16-1:0] src_data,
  output logic                  we_out,
  output logic [AW-1:0]         wAddr_out,
  output logic [15:0]           wData_out,
  output logic [SW-1:0]         active_mode,
  output logic                  switch_pending,
  output logic                  frame_done
);

  localparam logic [AW-1:0] LAST     = AW'(IMG_WIDTH*IMG_HEIGHT-1);
  localparam int            HW       = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES+1) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
  localparam bit            HOLD_EN  = (HOLD_FRAMES > 0);

  typedef enum logic [1:0] {SYNC, RUN, PEND} state_t;

  state_t        state, state_n;
  logic [SW-1:0] pending, pending_n, active_n, fwd_src;
  logic [HW-1:0] hold_cnt, cnt_n;
  logic          fwd_en, switching, req_ok, auto_req;
  logic          act_we, pend_we, fwd_we;
  logic [AW-1:0] act_addr, pend_addr, fwd_addr;
  logic [15:0]   fwd_data, data_n;
  logic          act_fs, act_fe, pend_fs;

  always_comb begin
    act_we    = src_we[active_mode];
    act_addr  = src_addr[int'(active_mode)*AW +: AW];
    pend_we   = src_we[pending];
    pend_addr = src_addr[int'(pending)*AW +: AW];
    act_fs    = act_we && (act_addr == '0);
    act_fe    = act_we && (act_addr == LAST);
    pend_fs   = pend_we && (pend_addr == '0);
  end

  // A switch takes effect on the pending source's frame-start beat, so that beat
  // already comes from the new source; a request in that cycle is judged against it.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    active_n  = active_mode;
    cnt_n     = hold_cnt;
    fwd_src   = active_mode;
    fwd_en    = 1'b0;
    switching = 1'b0;
    req_ok    = mode_req_valid && (32'(mode_req) < 32'(NUM_SRC));
    auto_req  = HOLD_EN && (active_mode != '0) && (hold_cnt == HOLD_MAX);
    case (state)
      SYNC: begin
        if (act_fs) begin
          fwd_en  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        fwd_en = 1'b1;
        if (req_ok && (mode_req != active_mode)) begin
          pending_n = mode_req;
          state_n   = PEND;
        end else if (auto_req) begin
          pending_n = '0;
          state_n   = PEND;
        end
      end
      PEND: begin
        fwd_en = 1'b1;
        if (pend_fs) begin
          switching = 1'b1;
          fwd_src   = pending;
          active_n  = pending;
          cnt_n     = '0;
          state_n   = RUN;
          if (req_ok && (mode_req != pending)) begin
            pending_n = mode_req;
            state_n   = PEND;
          end
        end else if (req_ok) begin
          if (mode_req == active_mode) state_n = RUN;
          else pending_n = mode_req;
        end
      end
      default: state_n = SYNC;
    endcase
    if (HOLD_EN && (state != SYNC) && !switching && act_fe &&
        (active_mode != '0) && (hold_cnt != HOLD_MAX))
      cnt_n = hold_cnt + 1'b1;
    fwd_we   = src_we[fwd_src];
    fwd_addr = src_addr[int'(fwd_src)*AW +: AW];
    fwd_data = src_data[int'(fwd_src)*16 +: 16];
  end

`ifdef SCHED_BLANK_SWITCH_EN
  logic blank_q, blank_now;

  // Blanking starts on the switch beat and ends at the next frame start of the active source.
  always_comb blank_now = switching || (blank_q && !act_fs);

  always_ff @(posedge clk) begin
    if (reset) blank_q <= 1'b0;
    else if (fwd_en) blank_q <= blank_now;
  end

  always_comb data_n = blank_now ? 16'h0000 : fwd_data;
`else
  always_comb data_n = fwd_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      pending     <= '0;
      active_mode <= '0;
      hold_cnt    <= '0;
      we_out      <= 1'b0;
      wAddr_out   <= '0;
      wData_out   <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      pending     <= pending_n;
      active_mode <= active_n;
      hold_cnt    <= cnt_n;
      we_out      <= fwd_en && fwd_we;
      wAddr_out   <= fwd_en ? fwd_addr : '0;
      wData_out   <= fwd_en ? data_n : 16'h0000;
      frame_done  <= fwd_en && fwd_we && (fwd_addr == LAST);
    end
  end

  assign switch_pending = (state == PEND);

endmodule

// File: tb/tb_filter_mode_scheduler.sv
// Self-checking bench for filter_mode_scheduler: 8x4 frames, four sources, hold of two frames.
// Source i drives data 16'h1000*i + addr; frames are separated by idle blanking beats.
module tb_filter_mode_scheduler;

  localparam int AW = 5;

`ifdef SCHED_BLANK_SWITCH_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode_req;
  logic        mode_req_valid;
  logic [3:0]  src_we;
  logic [19:0] src_addr;
  logic [63:0] src_data;
  logic        we_out;
  logic [4:0]  wAddr_out;
  logic [15:0] wData_out;
  logic [1:0]  active_mode;
  logic        switch_pending;
  logic        frame_done;

  logic [1:0]  mode_req3;
  logic        mode_req_valid3;
  logic [2:0]  src_we3;
  logic [14:0] src_addr3;
  logic [47:0] src_data3;
  logic        we_out3;
  logic [4:0]  wAddr_out3;
  logic [15:0] wData_out3;
  logic [1:0]  active_mode3;
  logic        switch_pending3;
  logic        frame_done3;

  filter_mode_scheduler #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .NUM_SRC(4), .HOLD_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
    .src_we(src_we), .src_addr(src_addr), .src_data(src_data),
    .we_out(we_out), .wAddr_out(wAddr_out), .wData_out(wData_out),
    .active_mode(active_mode), .switch_pending(switch_pending), .frame_done(frame_done)
  );

  // Three-source instance: the only way to present an out-of-range request index.
  filter_mode_scheduler #(.IMG_WIDTH(8), .IMG_HEIGHT(4), .NUM_SRC(3), .HOLD_FRAMES(2)) dut3 (
    .clk(clk), .reset(reset), .mode_req(mode_req3), .mode_req_valid(mode_req_valid3),
    .src_we(src_we3), .src_addr(src_addr3), .src_data(src_data3),
    .we_out(we_out3), .wAddr_out(wAddr_out3), .wData_out(wData_out3),
    .active_mode(active_mode3), .switch_pending(switch_pending3), .frame_done(frame_done3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [4:0] addr;
    logic       rv;
    logic [1:0] req;
    logic       e_we;
    logic [1:0] e_src;
    logic       e_blank;
    logic [1:0] e_mode;
    logic       e_pend;
  } vec_t;

  typedef struct {
    int          due;
    int          tag;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [1:0]  mode;
    logic        pend;
    logic        fd;
    logic        chk_ad;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   beat_no  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] addr,
                              input logic rv, input logic [1:0] req, input logic e_we,
                              input logic [1:0] e_src, input logic e_blank,
                              input logic [1:0] e_mode, input logic e_pend);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.rv = rv; v.req = req;
    v.e_we = e_we; v.e_src = e_src; v.e_blank = e_blank; v.e_mode = e_mode; v.e_pend = e_pend;
    return v;
  endfunction

  task automatic checkValue(input string name, input int tag, input logic [31:0] act,
                            input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s beat=%0d got=%0h expected=%0h", name, tag, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("we_out", e.tag, 32'(we_out), 32'(e.we));
    checkValue("active_mode", e.tag, 32'(active_mode), 32'(e.mode));
    checkValue("switch_pending", e.tag, 32'(switch_pending), 32'(e.pend));
    checkValue("frame_done", e.tag, 32'(frame_done), 32'(e.fd));
    if (e.chk_ad) begin
      checkValue("wAddr_out", e.tag, 32'(wAddr_out), 32'(e.addr));
      checkValue("wData_out", e.tag, 32'(wData_out), 32'(e.data));
    end
  endtask

  // Drives one beat, queues the outputs it must produce one clock later.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    reset          = v.rst;
    mode_req_valid = v.rv;
    mode_req       = v.req;
    for (int i = 0; i < 4; i++) begin
      src_we[i]             = v.we;
      src_addr[i*AW +: AW]  = v.addr;
      src_data[i*16 +: 16]  = 16'(i << 12) + {11'h000, v.addr};
    end
    for (int i = 0; i < 3; i++) begin
      src_we3[i]            = v.we;
      src_addr3[i*AW +: AW] = v.addr;
      src_data3[i*16 +: 16] = 16'(i << 12) + {11'h000, v.addr};
    end
    e.due    = cyc + 1;
    e.tag    = beat_no;
    e.we     = v.e_we;
    e.addr   = v.e_we ? v.addr : 5'd0;
    e.data   = (!v.e_we || v.e_blank) ? 16'h0000 : ({2'b00, v.e_src, 12'h000} + {11'h000, v.addr});
    e.mode   = v.e_mode;
    e.pend   = v.e_pend;
    e.fd     = v.e_we && (v.addr == 5'd31);
    e.chk_ad = v.e_we || v.rst;
    exp_q.push_back(e);
    beat_no++;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) checkOutput(exp_q.pop_front());
  end

  task automatic gapBeats(input int n, input logic [1:0] m, input logic p);
    for (int g = 0; g < n; g++) applyStimulus(mk(1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, m, p));
  endtask

  task automatic frameBeats(input logic [1:0] s, input logic b, input logic [1:0] m, input logic p);
    for (int a = 0; a < 32; a++) applyStimulus(mk(1'b0, 1'b1, 5'(a), 1'b0, 2'd0, 1'b1, s, b, m, p));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    reset = 1'b1; mode_req = 2'd0; mode_req_valid = 1'b0;
    src_we = '0; src_addr = '0; src_data = '0;
    mode_req3 = 2'd0; mode_req_valid3 = 1'b0;
    src_we3 = '0; src_addr3 = '0; src_data3 = '0;

    // Reset, partial first frame suppressed, request mode 2 at addr 10, switch at next frame.
    for (int r = 0; r < 2; r++) tbl.push_back(mk(1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
    for (int a = 12; a < 32; a++) tbl.push_back(mk(1'b0, 1'b1, 5'(a), 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
    for (int g = 0; g < 4; g++) tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0));
    for (int a = 0; a < 32; a++) tbl.push_back(mk(1'b0, 1'b1, 5'(a), a == 10, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, a >= 10));
    for (int g = 0; g < 4; g++) tbl.push_back(mk(1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1));
    for (int a = 0; a < 32; a++) tbl.push_back(mk(1'b0, 1'b1, 5'(a), 1'b0, 2'd0, 1'b1, 2'd2, BLANK, 2'd2, 1'b0));
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Second complete mode-2 frame triggers the auto-return to mode 0.
    gapBeats(4, 2'd2, 1'b0);
    frameBeats(2'd2, 1'b0, 2'd2, 1'b0);
    gapBeats(4, 2'd2, 1'b1);
    frameBeats(2'd0, BLANK, 2'd0, 1'b0);
    gapBeats(4, 2'd0, 1'b0);

    // Requests 1, 3, 0 back to back: latest wins, 0 cancels.
    for (int a = 0; a < 32; a++)
      applyStimulus(mk(1'b0, 1'b1, 5'(a), (a >= 5) && (a <= 7), (a == 5) ? 2'd1 : ((a == 6) ? 2'd3 : 2'd0),
                       1'b1, 2'd0, 1'b0, 2'd0, (a == 5) || (a == 6)));
    gapBeats(4, 2'd0, 1'b0);
    frameBeats(2'd0, 1'b0, 2'd0, 1'b0);
    gapBeats(4, 2'd0, 1'b0);

    // Request equal to active ignored; out-of-range ignored on the three-source instance.
    for (int a = 0; a < 32; a++) begin
      mode_req_valid3 = (a == 4) || (a == 6);
      mode_req3       = (a == 4) ? 2'd3 : 2'd2;
      applyStimulus(mk(1'b0, 1'b1, 5'(a), a == 3, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0));
      if (a == 4) begin
        checkValue("u3_oor_pending", a, 32'(switch_pending3), 32'd0);
        checkValue("u3_oor_mode", a, 32'(active_mode3), 32'd0);
      end
      if (a == 6) checkValue("u3_inrange_pending", a, 32'(switch_pending3), 32'd1);
    end
    mode_req_valid3 = 1'b0;

    // Switch to mode 3 during blanking, two frames, then auto-return.
    for (int g = 0; g < 4; g++)
      applyStimulus(mk(1'b0, 1'b0, 5'd0, g == 1, 2'd3, 1'b0, 2'd0, 1'b0, 2'd0, g >= 1));
    frameBeats(2'd3, BLANK, 2'd3, 1'b0);
    gapBeats(4, 2'd3, 1'b0);
    frameBeats(2'd3, 1'b0, 2'd3, 1'b0);
    gapBeats(4, 2'd3, 1'b1);

    // Request 1 on the very beat the return-to-0 switch completes.
    for (int a = 0; a < 32; a++)
      applyStimulus(mk(1'b0, 1'b1, 5'(a), a == 0, 2'd1, 1'b1, 2'd0, BLANK, 2'd0, 1'b1));
    gapBeats(4, 2'd0, 1'b1);
    frameBeats(2'd1, BLANK, 2'd1, 1'b0);
    gapBeats(4, 2'd1, 1'b0);

    // Reset while pending at addr 20: writes stop until the next frame start.
    for (int a = 0; a < 32; a++)
      applyStimulus(mk(a == 20, 1'b1, 5'(a), a == 5, 2'd2, a < 20, 2'd1, 1'b0,
                       (a < 20) ? 2'd1 : 2'd0, (a >= 5) && (a < 20)));
    gapBeats(4, 2'd0, 1'b0);
    frameBeats(2'd0, 1'b0, 2'd0, 1'b0);
    gapBeats(2, 2'd0, 1'b0);

    repeat (2) @(posedge clk);
    #6;
    checkValue("scoreboard_drain", beat_no, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
